// File: rtl/cdf_pkg.sv
// Shared types and default constants for the CDF histogram fetch stage.
package cdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } cdf_state_e;

  localparam int CDF_BINS   = 256;
  localparam int CDF_DATA_W = 20;
  localparam int CDF_ADDR_W = 16;
  localparam int CDF_TAG_W  = 16;

  localparam logic [CDF_TAG_W-1:0] CDF_TAG_VAL = 16'hAAAA;

  // Read word layout: bin value in the low bits, tag directly above it.
  localparam int CDF_DATA_LSB = 0;

endpackage

// File: rtl/cdf_skid_buf.sv
// Two-entry valid/ready buffer with synchronous flush; head entry drives the output.
module cdf_skid_buf #(
  parameter int W = 36
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = ent[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: only two entries, so they are reset to keep the output payload at zero out of reset.
      ent[0] <= '0;
      ent[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) begin
        ent[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/cdf_fetch_gen.sv
// Histogram-bin fetch stage: reads BINS tagged words from a bank and streams them out.
// Define CDF_ACCUM_EN to emit a saturating inclusive prefix sum instead of raw bin values.
module cdf_fetch_gen
  import cdf_pkg::*;
#(
  parameter int                BUS_W    = 128,
  parameter int                DATA_W   = CDF_DATA_W,
  parameter int                TAG_W    = CDF_TAG_W,
  parameter logic [TAG_W-1:0]  TAG_VAL  = TAG_W'(CDF_TAG_VAL),
  parameter int                ADDR_W   = CDF_ADDR_W,
  parameter int                BINS     = CDF_BINS,
  parameter int                BANK_W   = 1,
  parameter int                DONE_LAT = 2,
  parameter int                ERR_W    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BANK_W-1:0] bank_sel,
  output logic [ADDR_W-1:0] read_addr,
  output logic              read_en,
  input  logic [BUS_W-1:0]  read_bus,
  output logic [DATA_W-1:0] acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ADDR_W-1:0] store_addr,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  tag_err_cnt
);

  localparam int OFF_W   = ADDR_W - BANK_W;
  localparam int CNT_W   = $clog2(BINS) + 1;
  localparam int LAT_W   = $clog2(DONE_LAT + 1);
  localparam int PAY_W   = ADDR_W + DATA_W;
  localparam int TAG_LSB = CDF_DATA_LSB + DATA_W;

  cdf_state_e        state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  logic              issue, frame_start, flush, push, pop, drain_fire;
  logic [2:0]        occ;
  logic [1:0]        buf_count;
  logic [DATA_W-1:0] word_data, push_data, head_data;
  logic [TAG_W-1:0]  word_tag;
  logic              tag_bad;
  logic [PAY_W-1:0]  head_pay;
  logic              bus_unused;

  assign word_data  = read_bus[CDF_DATA_LSB +: DATA_W];
  assign word_tag   = read_bus[TAG_LSB +: TAG_W];
  assign bus_unused = ^read_bus[BUS_W-1:TAG_LSB+TAG_W];
  assign tag_bad    = (word_tag != TAG_VAL);
  assign push_data  = tag_bad ? '0 : word_data;

  // A returning word is only kept while the frame is still alive.
  assign push = inflight & ~flush;
  assign pop  = acc_valid & acc_ready;

  // Occupancy after this edge if nothing new is issued; issuing is allowed while it stays below 2.
  assign occ        = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
  assign drain_fire = (occ == 3'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt   = state;
    issue       = 1'b0;
    frame_start = 1'b0;
    flush       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_nxt   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!start) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (occ < 3'd2) begin
          issue = 1'b1;
          if (issue_cnt == CNT_W'(BINS - 1)) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!start) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (drain_fire && (lat_cnt == LAT_W'(DONE_LAT - 1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        flush     = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign read_en = issue;
  assign busy    = (state == ST_FETCH) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      read_addr     <= '0;
      issue_cnt     <= '0;
      lat_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      tag_err_cnt   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      inflight <= issue;
      if (issue) begin
        inflight_addr <= read_addr;
      end

      // The bank bits of read_addr are the latched base; only the offset counts, so it never leaves the bank.
      if (state == ST_IDLE) begin
        read_addr <= {bank_sel, OFF_W'(0)};
      end else if (issue) begin
        read_addr <= {read_addr[ADDR_W-1 -: BANK_W], read_addr[OFF_W-1:0] + OFF_W'(1)};
      end

      if (frame_start) begin
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end

      if (state != ST_DRAIN) begin
        lat_cnt <= '0;
      end else if (drain_fire) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      if (frame_start) begin
        tag_err_cnt <= '0;
      end else if (push && tag_bad && (tag_err_cnt != '1)) begin
        tag_err_cnt <= tag_err_cnt + ERR_W'(1);
      end
    end
  end

  cdf_skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (push),
    .in_data   ({inflight_addr, push_data}),
    .out_valid (acc_valid),
    .out_ready (acc_ready),
    .out_data  (head_pay),
    .count     (buf_count)
  );

  assign store_addr = head_pay[PAY_W-1:DATA_W];
  assign head_data  = head_pay[DATA_W-1:0];

`ifdef CDF_ACCUM_EN
  logic [DATA_W-1:0] run_sum;
  logic [DATA_W:0]   sum_wide;

  // The head beat is already folded in, so the output is an inclusive prefix sum that holds during stalls.
  assign sum_wide = {1'b0, run_sum} + {1'b0, head_data};
  assign acc_out  = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_sum <= '0;
    end else if (frame_start) begin
      run_sum <= '0;
    end else if (pop) begin
      run_sum <= acc_out;
    end
  end
`else
  assign acc_out = head_data;
`endif

endmodule

// File: tb/tb_cdf_fetch_gen.sv
// Directed bench for cdf_fetch_gen: memory model, in-order beat scoreboard, abort and reset cases.
module tb_cdf_fetch_gen;

  localparam int BINS     = 256;
  localparam int DONE_LAT = 2;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [0:0]   bank_sel;
  logic [15:0]  read_addr;
  logic         read_en;
  logic [127:0] read_bus;
  logic [19:0]  acc_out;
  logic         acc_valid;
  logic         acc_ready;
  logic [15:0]  store_addr;
  logic         busy;
  logic         done;
  logic [7:0]   tag_err_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rdy_ph   = 0;
  int          data_mode = 0;
  bit          err_mode  = 1'b0;
  int          ready_mode = 0;
  logic [15:0] exp_base = '0;
  int          beat_idx = 0;
  int          last_acc_cyc = 0;
  logic [19:0] model_sum = '0;
  bit          mon_en = 1'b0;

  cdf_fetch_gen dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .bank_sel    (bank_sel),
    .read_addr   (read_addr),
    .read_en     (read_en),
    .read_bus    (read_bus),
    .acc_out     (acc_out),
    .acc_valid   (acc_valid),
    .acc_ready   (acc_ready),
    .store_addr  (store_addr),
    .busy        (busy),
    .done        (done),
    .tag_err_cnt (tag_err_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [19:0] bin_data(input int idx);
    case (data_mode)
      1:       return 20'd1;
      2:       return 20'hFFFFF;
      default: return 20'(idx);
    endcase
  endfunction

  function automatic bit is_bad(input int idx);
    return err_mode && ((idx == 3) || (idx == 200));
  endfunction

  // Memory: one-cycle read latency; idle cycles return a bad-tag all-ones word.
  always @(posedge clock) begin : mem_model
    int idx;
    if (read_en) begin
      idx = int'(read_addr[7:0]);
      read_bus <= {92'b0, (is_bad(idx) ? 16'h5555 : 16'hAAAA), bin_data(idx)};
    end else begin
      read_bus <= '1;
    end
  end

  // Ready pattern changes just after the rising edge.
  initial begin
    acc_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       acc_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
        default: acc_ready = 1'b1;
      endcase
      rdy_ph++;
    end
  end

  // Every cycle with acc_valid must present the next expected beat, so stalls must hold it steady.
  always @(negedge clock) begin : monitor
    logic [19:0] raw;
    logic [19:0] ev;
    logic [20:0] s;
    if (mon_en && acc_valid) begin
      if (beat_idx >= BINS) begin
        check("extra_beat", {63'b0, acc_valid}, 64'd0);
      end else begin
        raw = is_bad(beat_idx) ? 20'd0 : bin_data(beat_idx);
`ifdef CDF_ACCUM_EN
        s  = {1'b0, model_sum} + {1'b0, raw};
        ev = s[20] ? 20'hFFFFF : s[19:0];
`else
        s  = {1'b0, raw};
        ev = s[19:0];
`endif
        check("store_addr", store_addr, exp_base + 16'(beat_idx));
        check("acc_out", acc_out, ev);
        if (acc_ready) begin
          model_sum    = ev;
          beat_idx     = beat_idx + 1;
          last_acc_cyc = cyc;
        end
      end
    end
  end

  task automatic setup_frame(input logic bank, input int dm, input bit em, input int rm);
    data_mode  = dm;
    err_mode   = em;
    ready_mode = rm;
    exp_base   = {bank, 15'b0};
    beat_idx   = 0;
    model_sum  = '0;
    mon_en     = 1'b1;
    bank_sel   = bank;
    start      = 1'b1;
  endtask

  task automatic run_frame(input logic bank, input int dm, input bit em, input int rm,
                           input int exp_err);
    int done_cyc;
    bit seen;
    setup_frame(bank, dm, em, rm);
    tick();
    check("busy_on_start", {63'b0, busy}, 64'd1);
    check("err_cleared", {56'b0, tag_err_cnt}, 64'd0);
    check("first_read_addr", {48'b0, read_addr}, {48'b0, exp_base});
    check("first_read_en", {63'b0, read_en}, 64'd1);
    tick();
    check("valid_early", {63'b0, acc_valid}, 64'd0);
    bank_sel = ~bank;
    tick();
    check("valid_first", {63'b0, acc_valid}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    done_cyc = cyc;
    check("done_seen", {63'b0, done}, 64'd1);
    check("beat_count", 64'(beat_idx), 64'(BINS));
    check("done_latency", 64'(done_cyc - last_acc_cyc), 64'(DONE_LAT));
    check("tag_err_cnt", {56'b0, tag_err_cnt}, 64'(exp_err));
    check("busy_in_done", {63'b0, busy}, 64'd0);
    repeat (3) tick();
    check("done_hold", {63'b0, done}, 64'd1);
    start  = 1'b0;
    mon_en = 1'b0;
    tick();
    check("done_clear", {63'b0, done}, 64'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    bank_sel = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {read_addr, read_en, acc_out, acc_valid, store_addr, busy, done, tag_err_cnt},
          '0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Bank 1, clean tags, index data, full-rate and stalled downstream, then two bad tags.
    run_frame(1'b1, 0, 1'b0, 0, 0);
    run_frame(1'b1, 0, 1'b0, 1, 0);
    run_frame(1'b1, 0, 1'b1, 0, 2);

    // Abort after 100 accepted beats (bad tag at index 3 already counted), then restart on bank 0.
    setup_frame(1'b1, 0, 1'b1, 0);
    for (int i = 0; i < 1000 && beat_idx < 100; i++) tick();
    check("abort_reached", 64'(beat_idx), 64'd100);
    start  = 1'b0;
    mon_en = 1'b0;
    tick();
    check("abort_valid", {63'b0, acc_valid}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_read_en", {63'b0, read_en}, 64'd0);
    run_frame(1'b0, 0, 1'b0, 0, 0);

`ifdef CDF_ACCUM_EN
    run_frame(1'b1, 1, 1'b0, 0, 0);
    run_frame(1'b1, 2, 1'b0, 0, 0);
`endif

    // Asynchronous reset in the middle of a stalled fetch.
    setup_frame(1'b1, 0, 1'b0, 1);
    repeat (40) tick();
    check("pre_reset_busy", {63'b0, busy}, 64'd1);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("async_rst_outputs",
          {read_addr, read_en, acc_out, acc_valid, store_addr, busy, done, tag_err_cnt}, '0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_reset_quiet", {60'b0, read_en, acc_valid, busy, done}, 64'd0);
    end
    run_frame(1'b1, 0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
